ksa_sub_pipe: RTL

Pipelined 8-bit Kogge-Stone subtractor with valid/ready handshakes on both sides. It computes `diff = a - b - bin` as `a + ~b + ~bin` on the same parallel-prefix carry network as the FMA datapath adders. Prefix levels are split across three register stages so the block closes timing at full FMA clock rate. It sits after the exponent/mantissa alignment path in the fused multiply-add unit, where the adder's inverse operation (exponent difference, effective subtraction) is needed.

---
 rtl/ksa_sub_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/ksa_sub_pipe.sv
// 8-bit Kogge-Stone subtractor (a - b - bin) split over three valid/ready pipeline stages.
// Optional build macro KSA_SUB_SAT_EN clamps the difference to the signed range on overflow.
module ksa_sub_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff,
    output logic       bout,
    output logic       ovf
);
    logic ld1, ld2, ld3;
    logic v1_q, v2_q, v3_q;

    // S1: bit-level propagate/generate of a + ~b, carry-in = ~bin
    logic [7:0] p0_s1_q, g0_s1_q, p0_s1_d, g0_s1_d;
    logic       cin_s1_q, cin_s1_d, a7_s1_q, b7_s1_q;

    // S2: prefix levels 1-2 (group spans up to 4)
    logic [7:0] gf, g1, g2_d, g2_q, p0_s2_q;
    logic [7:2] p1;
    logic [7:4] p2_d, p2_q;
    logic       cin_s2_q, a7_s2_q, b7_s2_q;

    // S3: level 3, carries and result
    logic [7:0] g3, raw, diff_d, diff_q;
    logic [8:0] carry;
    logic       bout_d, bout_q, ovf_d, ovf_q;

    // Each stage refills as soon as its own contents move on, so bubbles collapse.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = ld1;

    assign out_valid = v3_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

    always_comb begin
        p0_s1_d  = a ^ ~b;
        g0_s1_d  = a & ~b;
        cin_s1_d = ~bin;
    end

    // NOTE: every always_comb output gets a full default before any partial update, so no latch is inferred.
    always_comb begin
        gf    = g0_s1_q;
        gf[0] = g0_s1_q[0] | (p0_s1_q[0] & cin_s1_q);
        g1    = gf;
        p1    = '0;
        for (int i = 1; i < 8; i++) begin
            g1[i] = gf[i] | (p0_s1_q[i] & gf[i-1]);
        end
        for (int i = 2; i < 8; i++) begin
            p1[i] = p0_s1_q[i] & p0_s1_q[i-1];
        end
        g2_d = g1;
        p2_d = '0;
        for (int i = 2; i < 8; i++) begin
            g2_d[i] = g1[i] | (p1[i] & g1[i-2]);
        end
        for (int i = 4; i < 8; i++) begin
            p2_d[i] = p1[i] & p1[i-2];
        end
    end

    always_comb begin
        g3 = g2_q;
        for (int i = 4; i < 8; i++) begin
            g3[i] = g2_q[i] | (p2_q[i] & g2_q[i-4]);
        end
        carry  = {g3, cin_s2_q};
        raw    = p0_s2_q ^ carry[7:0];
        bout_d = ~carry[8];
        ovf_d  = (a7_s2_q ^ b7_s2_q) & (a7_s2_q ^ raw[7]);
`ifdef KSA_SUB_SAT_EN
        diff_d = ovf_d ? (a7_s2_q ? 8'h80 : 8'h7F) : raw;
`else
        diff_d = raw;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge values of the one before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            v3_q     <= 1'b0;
            // NOTE: data registers are reset too, so the outputs read zero right after reset.
            p0_s1_q  <= '0;
            g0_s1_q  <= '0;
            cin_s1_q <= 1'b0;
            a7_s1_q  <= 1'b0;
            b7_s1_q  <= 1'b0;
            p0_s2_q  <= '0;
            g2_q     <= '0;
            p2_q     <= '0;
            cin_s2_q <= 1'b0;
            a7_s2_q  <= 1'b0;
            b7_s2_q  <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (ld1) begin
                v1_q <= in_valid;
                if (in_valid) begin
                    p0_s1_q  <= p0_s1_d;
                    g0_s1_q  <= g0_s1_d;
                    cin_s1_q <= cin_s1_d;
                    a7_s1_q  <= a[7];
                    b7_s1_q  <= b[7];
                end
            end
            if (ld2) begin
                v2_q <= v1_q;
                if (v1_q) begin
                    p0_s2_q  <= p0_s1_q;
                    g2_q     <= g2_d;
                    p2_q     <= p2_d;
                    cin_s2_q <= cin_s1_q;
                    a7_s2_q  <= a7_s1_q;
                    b7_s2_q  <= b7_s1_q;
                end
            end
            if (ld3) begin
                v3_q <= v2_q;
                if (v2_q) begin
                    diff_q <= diff_d;
                    bout_q <= bout_d;
                    ovf_q  <= ovf_d;
                end
            end
        end
    end
endmodule
